cpu_ram_arbiter: RTL and testbench

Two-port arbiter sharing the 16-bit external port of the CPU RAM (write/address/wdata/rdata) between a high-priority requester (port 0, N64 PI side) and a low-priority requester (port 1, USB/DMA side). It sequences each access to fit the RAM's one-cycle registered read, holds the address through the data cycle so the halfword select stays valid, and bounds port-1 starvation with a burst limit. Sits between the requesters and the `if_cpu_ram.external` modport.

---
 rtl/cpu_ram_arbiter_if.sv | 29 ++
 rtl/cpu_ram_arbiter.sv | 79 +++++++
 tb/tb_cpu_ram_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_ram_arbiter_if.sv
// Bus bundle between the two RAM requesters, the arbiter and the CPU RAM external port.
interface cpu_ram_arbiter_if;
  logic        req0;
  logic        req1;
  logic        write0;
  logic        write1;
  logic [12:0] address0;
  logic [12:0] address1;
  logic [15:0] wdata0;
  logic [15:0] wdata1;
  logic        ack0;
  logic        ack1;
  logic [15:0] rdata0;
  logic [15:0] rdata1;
  logic        ram_write;
  logic [12:0] ram_address;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;

  modport master (
    output req0, req1, write0, write1, address0, address1, wdata0, wdata1, ram_rdata,
    input  ack0, ack1, rdata0, rdata1, ram_write, ram_address, ram_wdata
  );

  modport slave (
    input  req0, req1, write0, write1, address0, address1, wdata0, wdata1, ram_rdata,
    output ack0, ack1, rdata0, rdata1, ram_write, ram_address, ram_wdata
  );
endinterface

// File: rtl/cpu_ram_arbiter.sv
// Two-port arbiter for the CPU RAM external port: port 0 has priority,
// port 1 is guaranteed a grant after MAX_BURST contended port-0 grants.
module cpu_ram_arbiter #(
  parameter int unsigned MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              reset,
  cpu_ram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WRITE, READ_ADDR, READ_DATA} state_t;

  state_t      state;
  state_t      state_next;
  logic        sel;
  logic [7:0]  burst_cnt;
  logic        grant;
  logic        grant_port;
  logic        grant_write;
  logic        done;

  always_comb begin
    grant       = bus.req0 | bus.req1;
    grant_port  = bus.req1 & (~bus.req0 | (burst_cnt == 8'(MAX_BURST)));
    grant_write = grant_port ? bus.write1 : bus.write0;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (grant) state_next = grant_write ? WRITE : READ_ADDR;
      WRITE:     state_next = IDLE;
      READ_ADDR: state_next = READ_DATA;
      READ_DATA: state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Acks and read data are masked while reset is high so an aborted
  // transaction never reports completion in the reset cycle.
  always_comb begin
    bus.ack0   = 1'b0;
    bus.ack1   = 1'b0;
    bus.rdata0 = '0;
    bus.rdata1 = '0;
    done       = ((state == WRITE) || (state == READ_DATA)) && !reset;
    bus.ack0   = done & ~sel;
    bus.ack1   = done & sel;
    if ((state == READ_DATA) && !reset) begin
      if (sel) bus.rdata1 = bus.ram_rdata;
      else     bus.rdata0 = bus.ram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      sel             <= 1'b0;
      burst_cnt       <= '0;
      bus.ram_write   <= 1'b0;
      bus.ram_address <= '0;
      bus.ram_wdata   <= '0;
    end else begin
      state         <= state_next;
      bus.ram_write <= (state == IDLE) && grant && grant_write;
      if ((state == IDLE) && grant) begin
        sel             <= grant_port;
        bus.ram_address <= grant_port ? bus.address1 : bus.address0;
        bus.ram_wdata   <= grant_port ? bus.wdata1 : bus.wdata0;
        if (!grant_port && bus.req1) begin
          if (burst_cnt != 8'(MAX_BURST)) burst_cnt <= burst_cnt + 8'd1;
        end else begin
          burst_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu_ram_arbiter.sv
// Directed bench for cpu_ram_arbiter with a word-organised RAM model whose
// halfword select follows the live address bit 0.
module tb_cpu_ram_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   pass_cnt = 0;
  int   fail_cnt = 0;
  bit   mon_en = 1'b0;
  logic        prev_wr = 1'b0;
  logic [12:0] prev_addr = '0;

  cpu_ram_arbiter_if bus ();

  cpu_ram_arbiter #(.MAX_BURST(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:4095];
  logic [31:0] rd_q = '0;

  always @(posedge clk) begin
    if (bus.ram_write) begin
      if (bus.ram_address[0]) mem[bus.ram_address[12:1]][31:16] <= bus.ram_wdata;
      else                    mem[bus.ram_address[12:1]][15:0]  <= bus.ram_wdata;
    end
    rd_q <= mem[bus.ram_address[12:1]];
  end

  assign bus.ram_rdata = bus.ram_address[0] ? rd_q[31:16] : rd_q[15:0];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit p, input logic wr, input logic [12:0] a,
                       input logic [15:0] d, input logic rq);
    if (p) begin
      bus.req1 = rq; bus.write1 = wr; bus.address1 = a; bus.wdata1 = d;
    end else begin
      bus.req0 = rq; bus.write0 = wr; bus.address0 = a; bus.wdata0 = d;
    end
  endtask

  function automatic logic ack_of(input bit p);
    return p ? bus.ack1 : bus.ack0;
  endfunction

  function automatic logic [15:0] rdata_of(input bit p);
    return p ? bus.rdata1 : bus.rdata0;
  endfunction

  task automatic do_write(input bit p, input logic [12:0] a, input logic [15:0] d);
    drive(p, 1'b1, a, d, 1'b1);
    check("wr_idle_ack", ack_of(p), 0);
    step();
    check("wr_ram_write", bus.ram_write, 1);
    check("wr_ack", ack_of(p), 1);
    check("wr_other_ack", ack_of(!p), 0);
    check("wr_addr", bus.ram_address, a);
    check("wr_wdata", bus.ram_wdata, d);
    drive(p, 1'b0, '0, '0, 1'b0);
    step();
    check("wr_end_write", bus.ram_write, 0);
    check("wr_end_ack", ack_of(p), 0);
  endtask

  task automatic do_read(input bit p, input logic [12:0] a, input logic [15:0] exp);
    drive(p, 1'b0, a, '0, 1'b1);
    step();
    check("rd_addr_ack", ack_of(p), 0);
    check("rd_addr_write", bus.ram_write, 0);
    check("rd_addr_addr", bus.ram_address, a);
    step();
    check("rd_data_ack", ack_of(p), 1);
    check("rd_data_rdata", rdata_of(p), exp);
    check("rd_data_other", rdata_of(!p), 0);
    check("rd_data_addr", bus.ram_address, a);
    drive(p, 1'b0, '0, '0, 1'b0);
    step();
    check("rd_end_ack", ack_of(p), 0);
    check("rd_end_rdata", rdata_of(p), 0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("ack_onehot", {31'b0, bus.ack0 & bus.ack1}, 0);
      check("wr_pulse", {31'b0, bus.ram_write & prev_wr}, 0);
      if ((bus.ack0 | bus.ack1) && !bus.ram_write)
        check("addr_hold", bus.ram_address, prev_addr);
      prev_wr   = bus.ram_write;
      prev_addr = bus.ram_address;
    end
  end

  initial begin
    int n;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    drive(1'b1, 1'b0, '0, '0, 1'b0);
    repeat (3) step();
    reset = 1'b0;
    check("rst_ack0", bus.ack0, 0);
    check("rst_ack1", bus.ack1, 0);
    check("rst_rdata0", bus.rdata0, 0);
    check("rst_rdata1", bus.rdata1, 0);
    check("rst_ram_write", bus.ram_write, 0);
    check("rst_ram_address", bus.ram_address, 0);
    check("rst_ram_wdata", bus.ram_wdata, 0);
    mon_en = 1'b1;

    do_write(1'b1, 13'h0005, 16'hBEEF);
    do_read(1'b1, 13'h0005, 16'hBEEF);

    do_write(1'b0, 13'h0010, 16'h1111);
    do_write(1'b1, 13'h0011, 16'h2222);
    do_read(1'b0, 13'h0010, 16'h1111);
    do_read(1'b1, 13'h0011, 16'h2222);

    // Contention: 8 port-0 grants then 1 port-1 grant, twice.
    drive(1'b0, 1'b0, 13'h0010, '0, 1'b1);
    drive(1'b1, 1'b1, 13'h0030, 16'h5A5A, 1'b1);
    n = 0;
    for (int c = 0; c < 300 && n < 18; c++) begin
      step();
      if (bus.ack0 | bus.ack1) begin
        check("cont_grant", bus.ack1, ((n % 9) == 8) ? 1 : 0);
        if (bus.ack0) check("cont_rdata0", bus.rdata0, 16'h1111);
        n++;
        if (n == 18) begin
          drive(1'b0, 1'b0, '0, '0, 1'b0);
          drive(1'b1, 1'b0, '0, '0, 1'b0);
        end
      end
    end
    check("cont_grants", n, 18);
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    drive(1'b1, 1'b0, '0, '0, 1'b0);
    step();

    // Uncontended back-to-back port-0 reads: ack every third cycle.
    drive(1'b0, 1'b0, 13'h0011, '0, 1'b1);
    for (int t = 0; t < 60; t++) begin
      check("unc_ack0", bus.ack0, ((t % 3) == 2) ? 1 : 0);
      check("unc_ack1", bus.ack1, 0);
      if (bus.ack0) check("unc_rdata0", bus.rdata0, 16'h2222);
      if (t == 59) drive(1'b0, 1'b0, '0, '0, 1'b0);
      step();
    end
    check("unc_idle_ack0", bus.ack0, 0);

    // Reset during READ_DATA.
    drive(1'b1, 1'b0, 13'h0005, '0, 1'b1);
    step();
    step();
    reset = 1'b1;
    drive(1'b1, 1'b0, '0, '0, 1'b0);
    #1;
    check("rstrd_ack1", bus.ack1, 0);
    check("rstrd_rdata1", bus.rdata1, 0);
    step();
    reset = 1'b0;
    check("rstrd_post_ack1", bus.ack1, 0);
    check("rstrd_post_rdata1", bus.rdata1, 0);
    check("rstrd_post_addr", bus.ram_address, 0);
    check("rstrd_post_write", bus.ram_write, 0);
    check("rstrd_post_wdata", bus.ram_wdata, 0);
    step();
    check("rstrd_later_ack1", bus.ack1, 0);

    // Reset during WRITE: the RAM write still lands.
    drive(1'b0, 1'b1, 13'h0020, 16'hCAFE, 1'b1);
    step();
    check("rstwr_write", bus.ram_write, 1);
    reset = 1'b1;
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    step();
    reset = 1'b0;
    check("rstwr_post_write", bus.ram_write, 0);
    check("rstwr_post_addr", bus.ram_address, 0);
    check("rstwr_post_ack0", bus.ack0, 0);
    step();
    do_read(1'b0, 13'h0020, 16'hCAFE);
    do_read(1'b0, 13'h0005, 16'hBEEF);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
    $finish;
  end
endmodule
